// File: rtl/spi_slave_endpoint.sv
// Mode-0 SPI slave: oversampled in clk_cpu, parallel rx/tx ports.
// Optional sticky overrun flag: define SPI_SLAVE_OVERRUN_EN.
module spi_slave_endpoint #(
  parameter int WIDTH = 8
) (
  input  logic             clk_cpu,
  input  logic             rst,
  input  logic             SCK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state;

  logic [1:0] sck_sy;
  logic [1:0] ss_sy;
  logic [1:0] mosi_sy;
  logic       sck_d;
  logic       ss_d;
  logic       sck_rise;
  logic       sck_fall;
  logic       ss_fall;
  logic       ss_rise;

  logic [WIDTH-1:0] tx_buf;
  logic             tx_full;
  logic             tx_hs;

  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [CW-1:0]    cnt;
  logic             reload;

  logic             load;
  logic             done;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] rx_word;

  // Edge pulses are registered: they appear 3 cycles after the pin moves
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      sck_sy   <= '0;
      ss_sy    <= '0;
      mosi_sy  <= '0;
      sck_d    <= 1'b0;
      ss_d     <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      ss_fall  <= 1'b0;
      ss_rise  <= 1'b0;
    end else begin
      sck_sy   <= {sck_sy[0], SCK};
      ss_sy    <= {ss_sy[0], SS};
      mosi_sy  <= {mosi_sy[0], MOSI};
      sck_d    <= sck_sy[1];
      ss_d     <= ss_sy[1];
      sck_rise <= sck_sy[1] & ~sck_d;
      sck_fall <= ~sck_sy[1] & sck_d;
      ss_fall  <= ~ss_sy[1] & ss_d;
      ss_rise  <= ss_sy[1] & ~ss_d;
    end
  end

  assign tx_ready  = ~tx_full;
  assign tx_hs     = tx_valid & ~tx_full;
  assign load_word = tx_full ? tx_buf : '0;
  assign rx_word   = {rx_sr[WIDTH-2:0], mosi_sy[1]};

  always_comb begin
    load = 1'b0;
    done = 1'b0;
    if (state == IDLE) begin
      load = ss_fall;
    end else if (!ss_rise) begin
      load = sck_fall & reload;
      done = sck_rise & (cnt == CW'(WIDTH - 1));
    end
  end

  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (tx_hs) begin
      tx_buf  <= tx_data;
      tx_full <= 1'b1;
    end else if (load) begin
      tx_full <= 1'b0;
    end
  end

  // ss_rise outranks any SCK edge seen in the same cycle
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      MISO   <= 1'b0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      cnt    <= '0;
      reload <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ss_fall) begin
            state  <= ACTIVE;
            busy   <= 1'b1;
            tx_sr  <= load_word;
            MISO   <= load_word[WIDTH-1];
            cnt    <= '0;
            reload <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state  <= IDLE;
            busy   <= 1'b0;
            MISO   <= 1'b0;
            cnt    <= '0;
            reload <= 1'b0;
          end else if (sck_rise) begin
            rx_sr <= rx_word;
            if (done) begin
              cnt    <= '0;
              reload <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (sck_fall) begin
            if (reload) begin
              tx_sr  <= load_word;
              MISO   <= load_word[WIDTH-1];
              reload <= 1'b0;
            end else if (cnt != '0) begin
              tx_sr <= tx_sr << 1;
              MISO  <= tx_sr[WIDTH-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (done) begin
      rx_data  <= rx_word;
      rx_valid <= 1'b1;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk_cpu or negedge rst) begin
    if (!rst) begin
      rx_overrun <= 1'b0;
    end else if (done && rx_valid) begin
      rx_overrun <= 1'b1;
    end else if (rx_ack) begin
      rx_overrun <= 1'b0;
    end
  end
`else
  assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_endpoint.sv
// Directed bench for spi_slave_endpoint (WIDTH=8): vector table
// plus hand sequences for back-to-back, abort, overrun and reset.
module tb_spi_slave_endpoint;

  logic       clk_cpu = 1'b0;
  logic       rst     = 1'b0;
  logic       SCK     = 1'b0;
  logic       SS      = 1'b1;
  logic       MOSI    = 1'b0;
  logic       MISO;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  spi_slave_endpoint #(.WIDTH(8)) dut (
    .clk_cpu    (clk_cpu),
    .rst        (rst),
    .SCK        (SCK),
    .SS         (SS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .busy       (busy)
  );

  always #5 clk_cpu = ~clk_cpu;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         load;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic offer(input logic [7:0] w);
    @(negedge clk_cpu);
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk_cpu);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk_cpu);
    rx_ack = 1'b1;
    @(negedge clk_cpu);
    rx_ack = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge clk_cpu);
    SS = 1'b0;
    repeat (6) @(negedge clk_cpu);
  endtask

  task automatic ss_high();
    @(negedge clk_cpu);
    SS = 1'b1;
    repeat (6) @(negedge clk_cpu);
  endtask

  // Mode 0: MOSI set while SCK low, MISO sampled just before the rise
  task automatic send_bits(input logic [7:0] w, input int n,
                           input bit chk_lat, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      MOSI = w[7-i];
      repeat (5) @(negedge clk_cpu);
      got = {got[6:0], MISO};
      SCK = 1'b1;
      repeat (3) @(posedge clk_cpu);
      #1;
      if (chk_lat && i == 7) chk("rx_valid_early", rx_valid, 0);
      @(posedge clk_cpu);
      #1;
      if (chk_lat && i == 7) chk("rx_valid_lat4", rx_valid, 1);
      @(negedge clk_cpu);
      repeat (2) @(negedge clk_cpu);
      SCK = 1'b0;
    end
    repeat (2) @(negedge clk_cpu);
  endtask

  logic [7:0] got;
  logic [7:0] got2;
  logic       exp_ovr;

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{1'b1, 8'hF0, 8'h0F, 8'hF0, 8'h0F};
    vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80};

    repeat (3) @(negedge clk_cpu);
    chk("rst_miso", MISO, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", rx_overrun, 0);
    rst = 1'b1;
    repeat (8) @(negedge clk_cpu);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].load) begin
        offer(vecs[v].tx);
        chk("tx_ready_fall", tx_ready, 0);
      end
      ss_low();
      chk("busy_active", busy, 1);
      chk("tx_ready_after_load", tx_ready, 1);
      send_bits(vecs[v].mosi, 8, 1'b1, got);
      chk("vec_miso", got, vecs[v].exp_miso);
      chk("vec_rx_data", rx_data, vecs[v].exp_rx);
      ss_high();
      chk("busy_idle", busy, 0);
      chk("miso_idle", MISO, 0);
      ack();
      chk("ack_clears_valid", rx_valid, 0);
    end

    // Offer while full is ignored
    offer(8'h66);
    offer(8'h99);
    chk("full_ignores_valid", tx_ready, 0);
    ss_low();
    send_bits(8'hC3, 8, 1'b0, got);
    chk("full_first_word_kept", got, 8'h66);
    ss_high();
    ack();

    // Back-to-back frames with SS held low
    offer(8'h12);
    ss_low();
    offer(8'h34);
    send_bits(8'h81, 8, 1'b1, got);
    chk("b2b_miso0", got, 8'h12);
    chk("b2b_rx0", rx_data, 8'h81);
    ack();
    send_bits(8'h7E, 8, 1'b1, got2);
    chk("b2b_miso1", got2, 8'h34);
    chk("b2b_rx1", rx_data, 8'h7E);
    chk("b2b_valid1", rx_valid, 1);
    ss_high();
    ack();

    // Abort after 5 bits
    ss_low();
    send_bits(8'hFF, 5, 1'b0, got);
    ss_high();
    chk("abort_valid", rx_valid, 0);
    chk("abort_rx_data", rx_data, 8'h7E);
    chk("abort_busy", busy, 0);
    ss_low();
    send_bits(8'h55, 8, 1'b1, got);
    ss_high();
    chk("after_abort_rx", rx_data, 8'h55);
    chk("after_abort_miso", got, 8'h00);
    ack();

    // Two frames without ack
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    ss_low();
    send_bits(8'h11, 8, 1'b0, got);
    ss_high();
    chk("ovr_none_yet", rx_overrun, 0);
    ss_low();
    send_bits(8'h22, 8, 1'b0, got);
    ss_high();
    chk("ovr_flag", rx_overrun, exp_ovr);
    chk("ovr_rx_data", rx_data, 8'h22);
    chk("ovr_valid", rx_valid, 1);
    ack();
    chk("ovr_ack_valid", rx_valid, 0);
    chk("ovr_ack_flag", rx_overrun, 0);

    // Reset mid-frame with rx_valid set and buffer full
    ss_low();
    send_bits(8'h5A, 8, 1'b0, got);
    ss_high();
    offer(8'hAA);
    ss_low();
    offer(8'hBB);
    send_bits(8'hF0, 3, 1'b0, got);
    chk("pre_rst_busy", busy, 1);
    @(negedge clk_cpu);
    rst = 1'b0;
    #1;
    chk("mid_rst_miso", MISO, 0);
    chk("mid_rst_rx_data", rx_data, 0);
    chk("mid_rst_rx_valid", rx_valid, 0);
    chk("mid_rst_tx_ready", tx_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", rx_overrun, 0);
    SCK = 1'b0;
    SS  = 1'b1;
    repeat (3) @(negedge clk_cpu);
    rst = 1'b1;
    repeat (8) @(negedge clk_cpu);
    offer(8'h96);
    ss_low();
    send_bits(8'hC3, 8, 1'b1, got);
    ss_high();
    chk("post_rst_rx", rx_data, 8'hC3);
    chk("post_rst_miso", got, 8'h96);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_endpoint.md
# spi_slave_endpoint

Mode-0 SPI slave that sits directly downstream of the SPI master, on the far end of its SCK/MOSI/SS/MISO wires. Oversamples the serial lines in the local `clk_cpu` domain and deserialises MOSI into parallel words. Serialises a locally supplied word onto MISO in the same frame. Presents a simple valid/ack receive port and a valid/ready transmit port to local logic.

## Interface
- `WIDTH`, default 8: bits per frame, MSB first; legal range 2–32.
- `clk_cpu` in 1: system clock; all logic sits on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `SCK` in 1: serial clock from master; asynchronous to `clk_cpu`; idles low.
- `SS` in 1: slave select, active-low; asynchronous.
- `MOSI` in 1: serial data from master.
- `MISO` out 1: serial data to master.
- `tx_data` in WIDTH: word to send in the next frame.
- `tx_valid` in 1: `tx_data` is offered.
- `tx_ready` out 1: transmit buffer empty; the word is accepted when `tx_valid && tx_ready`.
- `rx_data` out WIDTH: last completed received word.
- `rx_valid` out 1: level; `rx_data` holds an unread word.
- `rx_ack` in 1: one-cycle pulse; clears `rx_valid` (and `rx_overrun`).
- `rx_overrun` out 1: sticky overrun flag (see Configuration).
- `busy` out 1: a frame is in progress (SS low, state ACTIVE).

## Operation
- Input conditioning:
  - `SCK`, `SS` and `MOSI` each pass through a 2-FF synchroniser.
  - A third register on `SCK`/`SS` provides edge detection: `sck_rise`, `sck_fall`, `ss_fall`, `ss_rise`.
- Transmit buffer:
  - One WIDTH-bit register with a full flag; `tx_ready = !full`.
  - The handshake sets full.
  - Loading into the shift register clears full.
- FSM states: IDLE and ACTIVE.
  - IDLE -> ACTIVE on `ss_fall`. The tx shift register loads the tx buffer if full; otherwise it loads all zeros. The bit counter clears.
  - ACTIVE, `sck_rise`: shift synchronised MOSI into the rx shift register LSB and increment the counter.
  - ACTIVE, `sck_fall` with the counter not 0: shift the tx register left.
  - The counter reaching WIDTH on `sck_rise` completes the frame:
    - `rx_data` takes the assembled word.
    - `rx_valid` is set.
    - The counter clears.
    - The tx shift register reloads from the buffer (or zeros) on the next `sck_fall`, so back-to-back frames work while SS stays low.
  - ACTIVE -> IDLE on `ss_rise`. Takes priority over a simultaneous SCK edge. Any partial word is discarded, with no `rx_valid` and no `rx_data` change. The counter clears.
- `MISO` is the tx shift register MSB while ACTIVE, and 0 in IDLE. No tri-state; an external buffer gates on SS.
- `rx_ack` and frame completion in the same cycle: completion wins, so `rx_valid` stays 1 with the new data.
- `tx_valid` while full: ignored; `tx_ready` stays 0.
- `busy` is 1 exactly while in ACTIVE.

## Timing
- Reset values: `MISO` 0, `rx_data` 0, `rx_valid` 0, `tx_ready` 1, `busy` 0, `rx_overrun` 0. FSM is IDLE, buffer is empty, synchronisers are cleared. SS low at reset release is treated as IDLE until the next `ss_fall`.
- Input-to-edge-detect latency is 3 `clk_cpu` cycles.
- The master requires:
  - SCK high and low phases of at least 4 `clk_cpu` cycles each.
  - SS low at least 4 cycles before the first SCK rise.
  - SS high at least 4 cycles between frames.
- `MISO` first-bit valid: 4 cycles after SS falls.
- `MISO` update: 4 cycles after each SCK fall.
- `rx_valid` rises 4 cycles after the final SCK rise.
- `tx_ready` falls the cycle after the handshake. It rises the cycle after the shift-register load.
- Reset mid-frame returns every state element to its reset value immediately.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - Frame completion while `rx_valid` is already 1 sets `rx_overrun`.
  - `rx_data` is still overwritten with the new word.
  - `rx_overrun` clears only on `rx_ack` or reset.
- Undefined: `rx_overrun` is tied to 0 and the detection logic is absent; overwrite behaviour is unchanged.

## Test plan
- WIDTH=8, tx buffer loaded with 0xA5, master sends 0x3C: MISO bit sequence 1,0,1,0,0,1,0,1; `rx_data`=0x3C; `rx_valid`=1 4 cycles after the 8th SCK rise; `tx_ready` back to 1.
- Empty tx buffer, master sends 0xFF: MISO stays 0 for the whole frame; `rx_data`=0xFF.
- Two frames with SS held low, tx words 0x12 then 0x34 (second word offered after the first load), master sends 0x81 then 0x7E: MISO shows 0x12 then 0x34; `rx_data` ends at 0x7E; `rx_valid` set after each frame.
- SS released after 5 SCK rises: `rx_valid` stays 0, `rx_data` unchanged, `busy` 0. The next full frame 0x55 is received correctly.
- Two frames with no `rx_ack` between them: with `SPI_SLAVE_OVERRUN_EN`, `rx_overrun`=1 and `rx_data` = second word, and `rx_ack` clears both flags. Without the macro, `rx_overrun` stays 0.
- `rst` asserted after 3 bits of a frame: all outputs return to reset values immediately. After release, a new frame 0xC3 is received correctly.
